reg_file_16x32: RTL and testbench



---
 rtl/reg_file_16x32_if.sv | 17 +
 rtl/reg_file_16x32.sv | 40 ++++
 tb/tb_reg_file_16x32.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/reg_file_16x32_if.sv
// reg_file_16x32_if: operand read ports, write port and init status bundle
interface reg_file_16x32_if #(
    parameter int WIDTH = 32,
    parameter int AW = 4
);
    logic [AW-1:0] rs_addr, rt_addr, rd_addr;
    logic [WIDTH-1:0] wr_data, rs_data, rt_data;
    logic wr_en, init_busy;
    modport master (
        output rs_addr, rt_addr, rd_addr, wr_data, wr_en,
        input rs_data, rt_data, init_busy
    );
    modport slave (
        input rs_addr, rt_addr, rd_addr, wr_data, wr_en,
        output rs_data, rt_data, init_busy
    );
endinterface

// File: rtl/reg_file_16x32.sv
// reg_file_16x32: 2R/1W register file with hardwired R0 and post-reset clear engine
module reg_file_16x32 #(
    parameter int NREG = 16,
    parameter int WIDTH = 32,
    parameter int AW = 4
) (
    input logic clk,
    input logic rst,
    reg_file_16x32_if.slave bus
);
    typedef enum logic [1:0] {HOLD, CLEAR, READY} state_t;
    state_t state, state_n;
    logic [AW-1:0] ptr, ptr_n;
    logic [WIDTH-1:0] regs [NREG];
    // Clear engine walks R1..R(NREG-1) once, then the file goes ready
    always_comb begin
        state_n = state == HOLD ? CLEAR : (state == CLEAR && ptr == AW'(NREG - 1)) ? READY : state;
        ptr_n = state == CLEAR ? ptr + AW'(1) : ptr;
    end
    // State and clear pointer; reset restarts the clear from R1
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HOLD;
            ptr <= AW'(1);
        end else begin
            state <= state_n;
            ptr <= ptr_n;
        end
    end
    // Storage: clear writes while busy, architectural writes only when ready; R0 never stored
    always_ff @(posedge clk) begin
        if (!rst && state == CLEAR)
            regs[ptr] <= '0;
        else if (!rst && state == READY && bus.wr_en && bus.rd_addr != '0)
            regs[bus.rd_addr] <= bus.wr_data;
    end
    assign bus.init_busy = state != READY;
    assign bus.rs_data = bus.init_busy || bus.rs_addr == '0 ? '0 : regs[bus.rs_addr];
    assign bus.rt_data = bus.init_busy || bus.rt_addr == '0 ? '0 : regs[bus.rt_addr];
endmodule

// File: tb/tb_reg_file_16x32.sv
// tb_reg_file_16x32: directed vectors checked against a cycle model of the register file
module tb_reg_file_16x32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] m [16];
    bit mbusy = 1'b1;
    bit valid = 1'b0;
    int cnt = 0;

    reg_file_16x32_if bus();
    reg_file_16x32 dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // Model: busy for 16 edges after reset release, file all-zero once that ends
    always @(posedge clk) begin
        if (rst) begin
            mbusy = 1'b1;
            cnt = 0;
            valid = 1'b1;
        end else if (mbusy) begin
            cnt++;
            if (cnt == 16) begin
                mbusy = 1'b0;
                for (int i = 0; i < 16; i++) m[i] = 32'h0;
            end
        end else if (bus.wr_en && bus.rd_addr != 4'd0)
            m[bus.rd_addr] = bus.wr_data;
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (valid) begin
            chk("busy", {31'b0, bus.init_busy}, {31'b0, mbusy});
            chk("rs_data", bus.rs_data, (mbusy || bus.rs_addr == 4'd0) ? 32'h0 : m[bus.rs_addr]);
            chk("rt_data", bus.rt_data, (mbusy || bus.rt_addr == 4'd0) ? 32'h0 : m[bus.rt_addr]);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.rd_addr = a;
        bus.wr_data = d;
        bus.wr_en = 1'b1;
        tick;
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [3:0] b, input logic [31:0] ea, input logic [31:0] eb, input string n);
        bus.rs_addr = a;
        bus.rt_addr = b;
        #1;
        chk({n, "_rs"}, bus.rs_data, ea);
        chk({n, "_rt"}, bus.rt_data, eb);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.rs_addr = 4'd0;
        bus.rt_addr = 4'd0;
        bus.rd_addr = 4'd0;
        bus.wr_data = 32'h0;
        bus.wr_en = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            chk("t1_busy", {31'b0, bus.init_busy}, (i <= 16) ? 32'd1 : 32'd0);
        end
        tick;
        for (int i = 1; i <= 15; i++) rd(4'(i), 4'(16 - i), 32'h0, 32'h0, "t1_zero");
        bus.rd_addr = 4'd5;
        bus.wr_data = 32'hDEADBEEF;
        bus.wr_en = 1'b1;
        rd(4'd5, 4'd5, 32'h0, 32'h0, "t2_old");
        tick;
        bus.wr_en = 1'b0;
        rd(4'd5, 4'd5, 32'hDEADBEEF, 32'hDEADBEEF, "t2_new");
        wr(4'd0, 32'hFFFFFFFF);
        rd(4'd0, 4'd0, 32'h0, 32'h0, "t3_r0");
        rd(4'd5, 4'd0, 32'hDEADBEEF, 32'h0, "t3_r5");
        wr(4'd1, 32'h1);
        rd(4'd1, 4'd2, 32'h1, 32'h0, "t6_a");
        wr(4'd2, 32'h2);
        rd(4'd1, 4'd2, 32'h1, 32'h2, "t6_b");
        wr(4'd1, 32'h3);
        rd(4'd1, 4'd2, 32'h3, 32'h2, "t6_c");
        wr(4'd3, 32'h77);
        rd(4'd3, 4'd3, 32'h77, 32'h77, "t4_pre");
        rst = 1'b1;
        bus.rd_addr = 4'd3;
        bus.wr_data = 32'h12345678;
        bus.wr_en = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), 4'(15 - i), 32'h0, 32'h0, "t4_clear");
            chk("t4_busy", {31'b0, bus.init_busy}, 32'd1);
            tick;
        end
        bus.wr_en = 1'b0;
        rd(4'd3, 4'd3, 32'h0, 32'h0, "t4_r3");
        chk("t4_ready", {31'b0, bus.init_busy}, 32'd0);
        wr(4'd7, 32'hA5A5A5A5);
        rd(4'd7, 4'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, "t5_pre");
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("t5_busy", {31'b0, bus.init_busy}, 32'd1);
            tick;
        end
        chk("t5_ready", {31'b0, bus.init_busy}, 32'd0);
        rd(4'd7, 4'd7, 32'h0, 32'h0, "t5_r7");
        rd(4'd5, 4'd1, 32'h0, 32'h0, "t5_r5r1");
        tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
